id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 5-stage CPU.
- Consumes the register file's combinational read data and the decode fields, and registers them for EX.
- Adds same-cycle write-back bypass, keeps held operands fresh while stalled, and detects load-use hazards by inserting one bubble.
- Sits between the register-file read in ID and the EX stage; also drives the ID stall (`in_ready`).

---
 rtl/pipe_pkg.sv | 48 ++++
 rtl/id_hazard_unit.sv | 30 +++
 rtl/id_ex_stage.sv | 121 ++++++++++++
 tb/tb_id_ex_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, ID/EX payload type and index helpers
//
// Purpose : common definitions for the ID/EX stage and the EX forwarding logic.
// Contents: XLEN / REG_ADDR_W datapath widths, ZERO_REG, id_ex_t payload,
//           idx_match() register-index compare, read_operand() bypassed read.
package pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int LU_CNT_W   = 16;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // Everything the EX stage needs from ID, apart from the valid bit.
  typedef struct packed {
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [REG_ADDR_W-1:0] rs1_index;
    logic [REG_ADDR_W-1:0] rs2_index;
    logic [REG_ADDR_W-1:0] rd_index;
    logic                  is_load;
  } id_ex_t;

  // True when a producer index names the same architectural register as a
  // consumer index. x0 never matches: it is hard-wired and never written.
  function automatic logic idx_match(input logic [REG_ADDR_W-1:0] producer,
                                     input logic [REG_ADDR_W-1:0] consumer);
    return (producer != ZERO_REG) && (producer == consumer);
  endfunction

  // Register read with same-cycle write-back bypass. The register file does
  // not see a write until the edge, so a write landing this cycle wins.
  function automatic logic [XLEN-1:0] read_operand(
      input logic [REG_ADDR_W-1:0] idx,
      input logic [XLEN-1:0]       rf_data,
      input logic                  wb_en,
      input logic [REG_ADDR_W-1:0] wb_idx,
      input logic [XLEN-1:0]       wb_data);
    if (idx == ZERO_REG) begin
      return '0;
    end else if (wb_en && idx_match(wb_idx, idx)) begin
      return wb_data;
    end else begin
      return rf_data;
    end
  endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// rtl/id_hazard_unit.sv - combinational load-use hazard detector
//
// Purpose : flags an ID instruction that reads the destination of a load
//           currently sitting in the ID/EX register.
// Ports   : ex_valid, ex_is_load, ex_rd_index - state of the ID/EX register
//           rs1_use, rs2_use, rs1_index, rs2_index - ID instruction sources
//           hz - load-use hazard, combinational
module id_hazard_unit
  import pipe_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd_index,
  input  logic                  rs1_use,
  input  logic                  rs2_use,
  input  logic [REG_ADDR_W-1:0] rs1_index,
  input  logic [REG_ADDR_W-1:0] rs2_index,
  output logic                  hz
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = rs1_use && idx_match(ex_rd_index, rs1_index);
    rs2_hit = rs2_use && idx_match(ex_rd_index, rs2_index);
    hz      = ex_valid && ex_is_load && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with bypass, hold-refresh and load-use stall
//
// Purpose : registers decoded operands/indices for EX, bypassing the WB write
//           port into the capture, refreshing held operands from WB while EX
//           back-pressures, and inserting one bubble on a load-use hazard.
// Ports   : clk, rst (async, active-low)
//           in_valid / in_ready                   - ID handshake
//           rs1/rs2/rd_index, rs1/rs2_use, is_load - decode fields
//           rs1_data_in, rs2_data_in              - register-file read data
//           wb_en, wb_rd_index, wb_data           - WB write port
//           flush                                 - kill the EX-bound slot
//           ex_ready                              - EX accepts the slot
//           out_*                                 - registered slot for EX
//           lu_stall_cnt                          - saturating load-use bubble count
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rs1_index,
  input  logic [REG_ADDR_W-1:0] rs2_index,
  input  logic [REG_ADDR_W-1:0] rd_index,
  input  logic                  rs1_use,
  input  logic                  rs2_use,
  input  logic                  is_load,
  input  logic [XLEN-1:0]       rs1_data_in,
  input  logic [XLEN-1:0]       rs2_data_in,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd_index,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  out_valid,
  output logic [XLEN-1:0]       out_rs1_data,
  output logic [XLEN-1:0]       out_rs2_data,
  output logic [REG_ADDR_W-1:0] out_rs1_index,
  output logic [REG_ADDR_W-1:0] out_rs2_index,
  output logic [REG_ADDR_W-1:0] out_rd_index,
  output logic                  out_is_load,
  output logic [LU_CNT_W-1:0]   lu_stall_cnt
);

  id_ex_t slot_q;
  id_ex_t slot_d;
  logic   valid_q;

  logic   hz;
  logic   adv;
  logic   take;
  logic   count_en;

  id_hazard_unit u_hazard (
    .ex_valid    (valid_q),
    .ex_is_load  (slot_q.is_load),
    .ex_rd_index (slot_q.rd_index),
    .rs1_use     (rs1_use),
    .rs2_use     (rs2_use),
    .rs1_index   (rs1_index),
    .rs2_index   (rs2_index),
    .hz          (hz)
  );

  always_comb begin
    // The register frees up when EX takes its content or it holds nothing.
    adv      = ex_ready || !valid_q;
    take     = adv && in_valid && !hz;
    // A flush consumes whatever ID offers, so ID may always move on then.
    in_ready = flush || (adv && !hz);
    count_en = in_valid && hz && adv && !flush;

    slot_d.rs1_data  = read_operand(rs1_index, rs1_data_in, wb_en, wb_rd_index, wb_data);
    slot_d.rs2_data  = read_operand(rs2_index, rs2_data_in, wb_en, wb_rd_index, wb_data);
    slot_d.rs1_index = rs1_index;
    slot_d.rs2_index = rs2_index;
    slot_d.rd_index  = rd_index;
    slot_d.is_load   = is_load;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (adv) begin
      // Either a new instruction or a bubble; a bubble keeps stale fields.
      valid_q <= take;
      if (take) begin
        slot_q <= slot_d;
      end
    end else begin
      // Held for EX: track WB so the operands are current when EX finally
      // takes them. The register file itself was already read at capture.
      if (wb_en && idx_match(wb_rd_index, slot_q.rs1_index)) begin
        slot_q.rs1_data <= wb_data;
      end
      if (wb_en && idx_match(wb_rd_index, slot_q.rs2_index)) begin
        slot_q.rs2_data <= wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_stall_cnt <= '0;
    end else if (count_en && (lu_stall_cnt != {LU_CNT_W{1'b1}})) begin
      lu_stall_cnt <= lu_stall_cnt + {{(LU_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid     = valid_q;
  assign out_rs1_data  = slot_q.rs1_data;
  assign out_rs2_data  = slot_q.rs2_data;
  assign out_rs1_index = slot_q.rs1_index;
  assign out_rs2_index = slot_q.rs2_index;
  assign out_rd_index  = slot_q.rd_index;
  assign out_is_load   = slot_q.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] rs1_index, rs2_index, rd_index;
  logic                  rs1_use, rs2_use, is_load;
  logic [XLEN-1:0]       rs1_data_in, rs2_data_in;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_rd_index;
  logic [XLEN-1:0]       wb_data;
  logic                  flush, ex_ready;
  logic                  out_valid;
  logic [XLEN-1:0]       out_rs1_data, out_rs2_data;
  logic [REG_ADDR_W-1:0] out_rs1_index, out_rs2_index, out_rd_index;
  logic                  out_is_load;
  logic [15:0]           lu_stall_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_index(rs1_index), .rs2_index(rs2_index), .rd_index(rd_index),
    .rs1_use(rs1_use), .rs2_use(rs2_use), .is_load(is_load),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .wb_en(wb_en), .wb_rd_index(wb_rd_index), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .out_valid(out_valid),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rs1_index(out_rs1_index), .out_rs2_index(out_rs2_index),
    .out_rd_index(out_rd_index), .out_is_load(out_is_load),
    .lu_stall_cnt(lu_stall_cnt)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

  task automatic set_idle();
    in_valid = 0; rs1_index = 0; rs2_index = 0; rd_index = 0;
    rs1_use = 0; rs2_use = 0; is_load = 0; rs1_data_in = 0; rs2_data_in = 0;
    wb_en = 0; wb_rd_index = 0; wb_data = 0; flush = 0; ex_ready = 1;
  endtask

  task automatic offer(input logic ld, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic u1, input logic u2,
                       input logic [31:0] d1, input logic [31:0] d2);
    in_valid = 1; is_load = ld; rd_index = rd; rs1_index = r1; rs2_index = r2;
    rs1_use = u1; rs2_use = u2; rs1_data_in = d1; rs2_data_in = d2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle(); rst = 0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", out_valid); end
    checks++; if (lu_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", lu_stall_cnt); end
    rst = 1;
    offer(1, 7, 2, 0, 1, 0, 32'h1, 32'h0); step();
    offer(0, 4, 7, 0, 1, 0, 32'h77, 32'h0); step();
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %0d expected 1", out_valid); end
    checks++; if (lu_stall_cnt !== 16'd1) begin errors++; $display("FAIL pre_reset_cnt: got %0d expected 1", lu_stall_cnt); end
    set_idle(); ex_ready = 0;
    #2; rst = 0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %0d expected 0", out_valid); end
    checks++; if (out_rs1_data !== 32'd0 || out_rs2_data !== 32'd0) begin errors++; $display("FAIL async_data: got %h/%h expected 0/0", out_rs1_data, out_rs2_data); end
    checks++; if (out_rs1_index !== 5'd0 || out_rs2_index !== 5'd0 || out_rd_index !== 5'd0) begin errors++; $display("FAIL async_index: got %0d/%0d/%0d expected 0/0/0", out_rs1_index, out_rs2_index, out_rd_index); end
    checks++; if (out_is_load !== 1'b0) begin errors++; $display("FAIL async_is_load: got %0d expected 0", out_is_load); end
    checks++; if (lu_stall_cnt !== 16'd0) begin errors++; $display("FAIL async_cnt: got %0d expected 0", lu_stall_cnt); end
    step(); rst = 1; ex_ready = 1; step();
    checks++; if (lu_stall_cnt !== 16'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset: got cnt=%0d valid=%0d expected 0/0", lu_stall_cnt, out_valid); end
    exp_cnt = 0;
  endtask

  task automatic test_bypass();
    set_idle();
    offer(0, 9, 5, 6, 1, 1, 32'h11, 32'h22); wb_en = 1; wb_rd_index = 5; wb_data = 32'hAB; step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %0d expected 1", out_valid); end
    checks++; if (out_rs1_data !== 32'hAB) begin errors++; $display("FAIL bypass_rs1: got %h expected ab", out_rs1_data); end
    checks++; if (out_rs2_data !== 32'h22) begin errors++; $display("FAIL bypass_rs2_plain: got %h expected 22", out_rs2_data); end
    offer(0, 9, 0, 0, 1, 1, 32'h11, 32'h99); wb_en = 1; wb_rd_index = 0; wb_data = 32'hAB; step();
    checks++; if (out_rs1_data !== 32'h0 || out_rs2_data !== 32'h0) begin errors++; $display("FAIL bypass_x0: got %h/%h expected 0/0", out_rs1_data, out_rs2_data); end
    offer(0, 9, 5, 6, 1, 1, 32'h11, 32'h22); wb_en = 1; wb_rd_index = 6; wb_data = 32'hCD; step();
    checks++; if (out_rs1_data !== 32'h11 || out_rs2_data !== 32'hCD) begin errors++; $display("FAIL bypass_rs2: got %h/%h expected 11/cd", out_rs1_data, out_rs2_data); end
    offer(0, 9, 5, 6, 1, 1, 32'h11, 32'h22); wb_en = 0; wb_rd_index = 5; wb_data = 32'hEE; step();
    checks++; if (out_rs1_data !== 32'h11) begin errors++; $display("FAIL bypass_wb_off: got %h expected 11", out_rs1_data); end
  endtask

  task automatic test_load_use();
    set_idle();
    offer(1, 7, 1, 0, 1, 0, 32'h5, 32'h0); step();
    checks++; if (out_is_load !== 1'b1 || out_rd_index !== 5'd7) begin errors++; $display("FAIL lu_load: got ld=%0d rd=%0d expected 1/7", out_is_load, out_rd_index); end
    offer(0, 8, 3, 7, 0, 1, 32'h33, 32'h44); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_ready: got %0d expected 0", in_ready); end
    step(); exp_cnt++;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %0d expected 0", out_valid); end
    checks++; if (lu_stall_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL lu_cnt: got %0d expected %0d", lu_stall_cnt, exp_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_after: got %0d expected 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_rs2_index !== 5'd7 || out_rd_index !== 5'd8) begin errors++; $display("FAIL lu_capture: got v=%0d rs2=%0d rd=%0d expected 1/7/8", out_valid, out_rs2_index, out_rd_index); end
    checks++; if (lu_stall_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL lu_cnt_once: got %0d expected %0d", lu_stall_cnt, exp_cnt); end
    offer(1, 7, 1, 0, 1, 0, 32'h5, 32'h0); step();
    offer(0, 8, 7, 7, 0, 0, 32'h33, 32'h44); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_nouse_ready: got %0d expected 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || lu_stall_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL lu_nouse: got v=%0d cnt=%0d expected 1/%0d", out_valid, lu_stall_cnt, exp_cnt); end
    offer(1, 0, 1, 0, 1, 0, 32'h5, 32'h0); step();
    offer(0, 8, 0, 0, 1, 1, 32'h0, 32'h0); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_x0_ready: got %0d expected 1", in_ready); end
    step();
  endtask

  task automatic test_hold_refresh();
    set_idle();
    offer(0, 9, 3, 4, 1, 1, 32'h10, 32'h20); step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_capture: got %0d expected 1", out_valid); end
    ex_ready = 0; offer(0, 10, 5, 6, 1, 1, 32'h1, 32'h2); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %0d expected 0", in_ready); end
    step();
    wb_en = 1; wb_rd_index = 3; wb_data = 32'h55; step();
    wb_en = 0; step();
    checks++; if (out_rs1_data !== 32'h55 || out_rs1_index !== 5'd3) begin errors++; $display("FAIL hold_refresh_rs1: got %h idx=%0d expected 55/3", out_rs1_data, out_rs1_index); end
    checks++; if (out_rs2_data !== 32'h20 || out_valid !== 1'b1) begin errors++; $display("FAIL hold_rs2: got %h v=%0d expected 20/1", out_rs2_data, out_valid); end
    ex_ready = 1; step();
    checks++; if (out_rs1_index !== 5'd5 || out_rs1_data !== 32'h1) begin errors++; $display("FAIL hold_release: got idx=%0d data=%h expected 5/1", out_rs1_index, out_rs1_data); end
  endtask

  task automatic test_flush();
    set_idle();
    offer(1, 7, 1, 0, 1, 0, 32'h5, 32'h0); step();
    ex_ready = 0; flush = 1; offer(0, 8, 7, 0, 1, 0, 32'h1, 32'h0); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0d expected 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || lu_stall_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL flush_kill: got v=%0d cnt=%0d expected 0/%0d", out_valid, lu_stall_cnt, exp_cnt); end
    flush = 0; ex_ready = 1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready: got %0d expected 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_rd_index !== 5'd8) begin errors++; $display("FAIL flush_next: got v=%0d rd=%0d expected 1/8", out_valid, out_rd_index); end
  endtask

  task automatic test_saturation();
    set_idle();
    for (int i = 0; i < 300; i++) begin
      offer(1, 7, 1, 0, 1, 0, 32'h5, 32'h0); step();
      offer(0, 8, 7, 0, 1, 0, 32'h1, 32'h0); step();
      exp_cnt++;
    end
    checks++; if (lu_stall_cnt !== exp_cnt[15:0]) begin errors++; $display("FAIL sat_count: got %0d expected %0d", lu_stall_cnt, exp_cnt); end
    force dut.lu_stall_cnt = 16'hFFFF;
    offer(1, 7, 1, 0, 1, 0, 32'h5, 32'h0); step();
    offer(0, 8, 7, 0, 1, 0, 32'h1, 32'h0); step();
    release dut.lu_stall_cnt; #1;
    checks++; if (lu_stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold1: got %h expected ffff", lu_stall_cnt); end
    offer(1, 7, 1, 0, 1, 0, 32'h5, 32'h0); step();
    offer(0, 8, 7, 0, 1, 0, 32'h1, 32'h0); step();
    checks++; if (lu_stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold2: got %h expected ffff", lu_stall_cnt); end
  endtask

  task automatic test_random();
    logic [31:0] regs [32];
    logic        m_valid, m_ld;
    logic [4:0]  m_i1, m_i2, m_rd;
    int          m_cnt;
    bit          e_hz, e_adv;
    logic [31:0] e1, e2;
    set_idle(); rst = 0; step(); rst = 1;
    m_valid = 0; m_ld = 0; m_i1 = 0; m_i2 = 0; m_rd = 0; m_cnt = 0;
    for (int r = 0; r < 32; r++) regs[r] = (r == 0) ? 32'h0 : $urandom;
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      rs1_index = 5'($urandom_range(0, 7)); rs2_index = 5'($urandom_range(0, 7));
      rd_index = 5'($urandom_range(0, 7));
      rs1_use = ($urandom_range(0, 9) < 7); rs2_use = ($urandom_range(0, 9) < 7);
      is_load = ($urandom_range(0, 9) < 4);
      // The register file returns the pre-write value; x0 reads return junk.
      rs1_data_in = (rs1_index == 0) ? $urandom : regs[rs1_index];
      rs2_data_in = (rs2_index == 0) ? $urandom : regs[rs2_index];
      wb_en = $urandom_range(0, 1); wb_rd_index = 5'($urandom_range(0, 7)); wb_data = $urandom;
      flush = ($urandom_range(0, 9) == 0); ex_ready = ($urandom_range(0, 9) < 7);
      #1;
      e_hz = m_valid && m_ld && (m_rd != 0) &&
             ((rs1_use && rs1_index == m_rd) || (rs2_use && rs2_index == m_rd));
      e_adv = ex_ready || !m_valid;
      checks++; if (in_ready !== (flush || (e_adv && !e_hz))) begin errors++; $display("FAIL rnd_ready c=%0d: got %0d expected %0d", c, in_ready, flush || (e_adv && !e_hz)); end
      if (in_valid && e_hz && e_adv && !flush && m_cnt < 65535) m_cnt++;
      if (flush) m_valid = 0;
      else if (e_adv) begin
        if (in_valid && !e_hz) begin
          m_valid = 1; m_ld = is_load; m_i1 = rs1_index; m_i2 = rs2_index; m_rd = rd_index;
        end else m_valid = 0;
      end
      if (wb_en && wb_rd_index != 0) regs[wb_rd_index] = wb_data;
      step();
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c=%0d: got %0d expected %0d", c, out_valid, m_valid); end
      checks++; if (lu_stall_cnt !== m_cnt[15:0]) begin errors++; $display("FAIL rnd_cnt c=%0d: got %0d expected %0d", c, lu_stall_cnt, m_cnt); end
      if (m_valid) begin
        // A live slot always carries the current architectural register values.
        e1 = regs[m_i1]; e2 = regs[m_i2];
        checks++; if (out_rs1_index !== m_i1 || out_rs2_index !== m_i2 || out_rd_index !== m_rd || out_is_load !== m_ld) begin errors++; $display("FAIL rnd_fields c=%0d: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", c, out_rs1_index, out_rs2_index, out_rd_index, out_is_load, m_i1, m_i2, m_rd, m_ld); end
        checks++; if (out_rs1_data !== e1 || out_rs2_data !== e2) begin errors++; $display("FAIL rnd_data c=%0d: got %h/%h expected %h/%h", c, out_rs1_data, out_rs2_data, e1, e2); end
      end
    end
  endtask

  initial begin
    set_idle(); rst = 0;
    test_reset();
    test_bypass();
    test_load_use();
    test_hold_refresh();
    test_flush();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
